// File: rtl/clk_period_meter_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : clk_period_meter_pkg                                      |
// | Purpose  : Shared types and default constants for clk_period_meter.  |
// |            Holds the measurement FSM state encoding and the default  |
// |            counter width and timeout.                                |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
package clk_period_meter_pkg;

  // Default width of the period / high-time counters and outputs.
  localparam int DEF_CNT_W   = 32;
  // Default timeout in Clk_In cycles (10 ms at 100 MHz).
  localparam int DEF_TIMEOUT = 1000000;

  typedef enum logic [0:0] {
    IDLE    = 1'b0,  // unarmed, waiting for the first rising edge
    MEASURE = 1'b1   // counting cycles between rising edges
  } state_t;

endpackage
`default_nettype wire

// File: rtl/clk_period_meter_if.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : clk_period_meter_if                                       |
// | Purpose  : Measurement bus of clk_period_meter.                      |
// |   Meas_In     : slow clock under measurement (async to Clk_In)       |
// |   Period_Out  : last measured period in Clk_In cycles                |
// |   Valid_Out   : one-cycle pulse when Period_Out is updated           |
// |   Timeout_Out : high while the measured clock is considered lost     |
// |   High_Out    : Clk_In cycles Meas_In was high in the last period    |
// |                 (only when CLK_METER_DUTY_EN is defined)             |
// |   master modport : the meter;  slave modport : the consumer          |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
interface clk_period_meter_if
  import clk_period_meter_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
);
  logic             Meas_In;
  logic [CNT_W-1:0] Period_Out;
  logic             Valid_Out;
  logic             Timeout_Out;
`ifdef CLK_METER_DUTY_EN
  logic [CNT_W-1:0] High_Out;

  modport master (input Meas_In, output Period_Out, Valid_Out, Timeout_Out, High_Out);
  modport slave  (output Meas_In, input Period_Out, Valid_Out, Timeout_Out, High_Out);
`else
  modport master (input Meas_In, output Period_Out, Valid_Out, Timeout_Out);
  modport slave  (output Meas_In, input Period_Out, Valid_Out, Timeout_Out);
`endif
endinterface
`default_nettype wire

// File: rtl/clk_period_meter_sync_edge_det.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : sync_edge_det                                             |
// | Purpose  : Two-flop synchronizer followed by a rising-edge detector. |
// |   clk      : sampling clock                                          |
// |   rst      : asynchronous active-high reset                          |
// |   i_async  : asynchronous input                                      |
// |   o_level  : synchronized level                                      |
// |   o_rise   : one-cycle pulse on a synchronized rising edge           |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module sync_edge_det (
  input  wire logic clk,
  input  wire logic rst,
  input  wire logic i_async,
  output logic      o_level,
  output logic      o_rise
);
  logic r_sync1;
  logic r_sync2;
  logic r_dly;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_dly   <= 1'b0;
    end else begin
      r_sync1 <= i_async;
      r_sync2 <= r_sync1;
      r_dly   <= r_sync2;
    end
  end

  assign o_level = r_sync2;
  assign o_rise  = r_sync2 & ~r_dly;
endmodule
`default_nettype wire

// File: rtl/clk_period_meter.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : clk_period_meter                                          |
// | Purpose  : Measures the period of a slow asynchronous clock in       |
// |            Clk_In cycles, flags loss of the clock after TIMEOUT      |
// |            cycles and optionally measures its high time.             |
// |   Clk_In : system clock (only clock)                                 |
// |   RST    : asynchronous active-high reset                            |
// |   bus    : clk_period_meter_if.master (Meas_In in, results out)      |
// | Macro    : CLK_METER_DUTY_EN enables the high-time counter/High_Out  |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module clk_period_meter
  import clk_period_meter_pkg::*;
#(
  parameter int CNT_W   = DEF_CNT_W,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  wire logic           Clk_In,
  input  wire logic           RST,
  clk_period_meter_if.master  bus
);
  localparam logic [CNT_W-1:0] c_cnt_one   = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] c_cnt_max   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] c_timeout   = CNT_W'(TIMEOUT);

  logic             w_level;
  logic             w_rise;
  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_period;
  logic             r_valid;
  logic             r_timeout;

  sync_edge_det u_sync (
    .clk     (Clk_In),
    .rst     (RST),
    .i_async (bus.Meas_In),
    .o_level (w_level),
    .o_rise  (w_rise)
  );

`ifdef CLK_METER_DUTY_EN
  logic [CNT_W-1:0] r_high_cnt;
  logic [CNT_W-1:0] r_high_out;
  // High-time restart value: the edge cycle itself is a high cycle.
  logic [CNT_W-1:0] w_high_start;
  assign w_high_start = w_level ? c_cnt_one : '0;
`else
  logic w_unused_level;
  assign w_unused_level = w_level;
`endif

  always_ff @(posedge Clk_In or posedge RST) begin
    if (RST) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_period   <= '0;
      r_valid    <= 1'b0;
      r_timeout  <= 1'b0;
`ifdef CLK_METER_DUTY_EN
      r_high_cnt <= '0;
      r_high_out <= '0;
`endif
    end else begin
      r_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          // First edge only arms; Timeout_Out is left as is so a lost
          // clock stays flagged until a full period has been measured.
          if (w_rise) begin
            r_state    <= MEASURE;
            r_cnt      <= c_cnt_one;
`ifdef CLK_METER_DUTY_EN
            r_high_cnt <= w_high_start;
`endif
          end
        end
        MEASURE: begin
          // The edge test comes first so an edge on the timeout cycle
          // still counts as a measurement.
          if (w_rise) begin
            r_period   <= r_cnt;
            r_valid    <= 1'b1;
            r_cnt      <= c_cnt_one;
            r_timeout  <= 1'b0;
`ifdef CLK_METER_DUTY_EN
            r_high_out <= r_high_cnt;
            r_high_cnt <= w_high_start;
`endif
          end else if (r_cnt >= c_timeout) begin
            r_state   <= IDLE;
            r_timeout <= 1'b1;
            r_period  <= '0;
            r_cnt     <= '0;
          end else begin
            if (r_cnt != c_cnt_max) begin
              r_cnt <= r_cnt + c_cnt_one;
            end
`ifdef CLK_METER_DUTY_EN
            if (w_level && (r_high_cnt != c_cnt_max)) begin
              r_high_cnt <= r_high_cnt + c_cnt_one;
            end
`endif
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.Period_Out  = r_period;
  assign bus.Valid_Out   = r_valid;
  assign bus.Timeout_Out = r_timeout;
`ifdef CLK_METER_DUTY_EN
  assign bus.High_Out    = r_high_out;
`endif
endmodule
`default_nettype wire

// File: tb/tb_clk_period_meter.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_clk_period_meter                                       |
// | Purpose  : Self-checking bench for clk_period_meter. Instance A uses |
// |            TIMEOUT=5000 with periods scaled down by ten (2500/2000   |
// |            instead of 25000/20000); instance B uses TIMEOUT=100.     |
// |            High-time checks run when CLK_METER_DUTY_EN is defined.   |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module tb_clk_period_meter;
  typedef struct { logic [31:0] p; logic [31:0] h; int c; } obs_t;
  typedef struct { logic [31:0] p; logic [31:0] h; } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  obs_t obs_a[$], obs_b[$];
  exp_t exp_a[$], exp_b[$];
  int   vcnt_a = 0, vcnt_b = 0;
  bit   prev_va = 1'b0, prev_vb = 1'b0;

  clk_period_meter_if #(.CNT_W(32)) ifa ();
  clk_period_meter_if #(.CNT_W(32)) ifb ();

  clk_period_meter #(.CNT_W(32), .TIMEOUT(5000)) u_dut_a (.Clk_In(clk), .RST(rst), .bus(ifa));
  clk_period_meter #(.CNT_W(32), .TIMEOUT(100))  u_dut_b (.Clk_In(clk), .RST(rst), .bus(ifb));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Capture every Valid_Out pulse (and count high cycles to catch wide pulses).
  always @(negedge clk) begin
    obs_t o;
    if (ifa.Valid_Out === 1'b1) begin
      vcnt_a++;
      o.p = ifa.Period_Out; o.c = cyc;
`ifdef CLK_METER_DUTY_EN
      o.h = ifa.High_Out;
`else
      o.h = '0;
`endif
      if (!prev_va) obs_a.push_back(o);
    end
    prev_va = (ifa.Valid_Out === 1'b1);
    if (ifb.Valid_Out === 1'b1) begin
      vcnt_b++;
      o.p = ifb.Period_Out; o.h = '0; o.c = cyc;
      if (!prev_vb) obs_b.push_back(o);
    end
    prev_vb = (ifb.Valid_Out === 1'b1);
  end

  task automatic do_reset();
    @(negedge clk);
    ifa.Meas_In = 1'b0; ifb.Meas_In = 1'b0; rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    obs_a.delete(); obs_b.delete(); exp_a.delete(); exp_b.delete();
    vcnt_a = 0; vcnt_b = 0;
  endtask

  // One Meas_In period of hi+lo cycles starting with a rising edge; t = cyc at the rise.
  task automatic wave_a(input int hi, input int lo, output int t);
    @(negedge clk); ifa.Meas_In = 1'b1; t = cyc;
    repeat (hi) @(negedge clk);
    ifa.Meas_In = 1'b0;
    repeat (lo - 1) @(negedge clk);
  endtask

  task automatic wave_b(input int hi, input int lo, output int t);
    @(negedge clk); ifb.Meas_In = 1'b1; t = cyc;
    repeat (hi) @(negedge clk);
    ifb.Meas_In = 1'b0;
    repeat (lo - 1) @(negedge clk);
  endtask

  task automatic test_reset();
    ifa.Meas_In = 1'b0; ifb.Meas_In = 1'b0;
    #1 rst = 1'b1;
    #1;  // before any clock edge: reset must act asynchronously
    n_cmp++; if (ifa.Period_Out !== 32'd0) begin n_bad++; $display("FAIL rst_period_a: got %0d, want 0", ifa.Period_Out); end
    n_cmp++; if (ifa.Valid_Out !== 1'b0) begin n_bad++; $display("FAIL rst_valid_a: got %b, want 0", ifa.Valid_Out); end
    n_cmp++; if (ifa.Timeout_Out !== 1'b0) begin n_bad++; $display("FAIL rst_timeout_a: got %b, want 0", ifa.Timeout_Out); end
    n_cmp++; if (ifb.Period_Out !== 32'd0) begin n_bad++; $display("FAIL rst_period_b: got %0d, want 0", ifb.Period_Out); end
    n_cmp++; if (ifb.Valid_Out !== 1'b0) begin n_bad++; $display("FAIL rst_valid_b: got %b, want 0", ifb.Valid_Out); end
    n_cmp++; if (ifb.Timeout_Out !== 1'b0) begin n_bad++; $display("FAIL rst_timeout_b: got %b, want 0", ifb.Timeout_Out); end
`ifdef CLK_METER_DUTY_EN
    n_cmp++; if (ifa.High_Out !== 32'd0) begin n_bad++; $display("FAIL rst_high_a: got %0d, want 0", ifa.High_Out); end
`endif
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_square_wave();
    int t, t2, lat;
    obs_t o; exp_t e;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      wave_a(1250, 1250, t);
      if (i == 1) t2 = t;
      if (i > 0) exp_a.push_back('{p: 32'd2500, h: 32'd1250});
    end
    lat = (obs_a.size() > 0) ? obs_a[0].c - t2 : -1;
    n_cmp++; if (lat != 3) begin n_bad++; $display("FAIL sq_latency: got %0d, want 3", lat); end
    n_cmp++; if (vcnt_a != 3) begin n_bad++; $display("FAIL sq_valid_cycles: got %0d, want 3", vcnt_a); end
    n_cmp++; if (obs_a.size() != exp_a.size()) begin n_bad++; $display("FAIL sq_count: got %0d, want %0d", obs_a.size(), exp_a.size()); end
    while (exp_a.size() != 0) begin
      e = exp_a.pop_front(); n_cmp++;
      if (obs_a.size() == 0) begin n_bad++; $display("FAIL sq_period: got none, want %0d", e.p); end
      else begin o = obs_a.pop_front(); if (o.p !== e.p) begin n_bad++; $display("FAIL sq_period: got %0d, want %0d", o.p, e.p); end end
    end
  endtask

  task automatic test_period_change();
    int t;
    obs_t o; exp_t e;
    do_reset();
    wave_a(1250, 1250, t);
    wave_a(1250, 1250, t); exp_a.push_back('{p: 32'd2500, h: 32'd0});
    wave_a(1000, 1000, t); exp_a.push_back('{p: 32'd2500, h: 32'd0});
    wave_a(1000, 1000, t); exp_a.push_back('{p: 32'd2000, h: 32'd0});
    wave_a(10, 10, t);     exp_a.push_back('{p: 32'd2000, h: 32'd0});
    n_cmp++; if (obs_a.size() != exp_a.size()) begin n_bad++; $display("FAIL chg_count: got %0d, want %0d", obs_a.size(), exp_a.size()); end
    while (exp_a.size() != 0) begin
      e = exp_a.pop_front(); n_cmp++;
      if (obs_a.size() == 0) begin n_bad++; $display("FAIL chg_period: got none, want %0d", e.p); end
      else begin o = obs_a.pop_front(); if (o.p !== e.p) begin n_bad++; $display("FAIL chg_period: got %0d, want %0d", o.p, e.p); end end
    end
  endtask

  task automatic test_reset_mid();
    int t;
    obs_t o; exp_t e;
    do_reset();
    wave_a(500, 2000, t);
    wave_a(500, 500, t); exp_a.push_back('{p: 32'd2500, h: 32'd0});
    // 1000 cycles into the period, Meas_In low: assert reset mid-cycle.
    @(negedge clk); #3 rst = 1'b1; #1;
    n_cmp++; if (ifa.Period_Out !== 32'd0) begin n_bad++; $display("FAIL mid_rst_period: got %0d, want 0", ifa.Period_Out); end
    n_cmp++; if (ifa.Valid_Out !== 1'b0) begin n_bad++; $display("FAIL mid_rst_valid: got %b, want 0", ifa.Valid_Out); end
    n_cmp++; if (ifa.Timeout_Out !== 1'b0) begin n_bad++; $display("FAIL mid_rst_timeout: got %b, want 0", ifa.Timeout_Out); end
    @(negedge clk); rst = 1'b0;
    repeat (1498) @(negedge clk);
    wave_a(500, 2000, t);  // arms only
    wave_a(10, 10, t); exp_a.push_back('{p: 32'd2500, h: 32'd0});
    n_cmp++; if (obs_a.size() != exp_a.size()) begin n_bad++; $display("FAIL mid_count: got %0d, want %0d", obs_a.size(), exp_a.size()); end
    while (exp_a.size() != 0) begin
      e = exp_a.pop_front(); n_cmp++;
      if (obs_a.size() == 0) begin n_bad++; $display("FAIL mid_period: got none, want %0d", e.p); end
      else begin o = obs_a.pop_front(); if (o.p !== e.p) begin n_bad++; $display("FAIL mid_period: got %0d, want %0d", o.p, e.p); end end
    end
  endtask

  task automatic test_timeout();
    int t, t0, got, dt;
    obs_t o; exp_t e;
    do_reset();
    wave_b(5, 35, t);
    wave_b(5, 1, t0); exp_b.push_back('{p: 32'd40, h: 32'd0});
    got = 0; dt = -1;
    for (int i = 0; i < 400 && got == 0; i++) begin
      @(negedge clk);
      if (ifb.Timeout_Out === 1'b1) begin got = 1; dt = cyc - t0; end
    end
    n_cmp++; if (dt != 103) begin n_bad++; $display("FAIL to_assert_cycle: got %0d, want 103", dt); end
    n_cmp++; if (ifb.Period_Out !== 32'd0) begin n_bad++; $display("FAIL to_period_zero: got %0d, want 0", ifb.Period_Out); end
    wave_b(5, 45, t);  // arms; timeout flag must persist
    n_cmp++; if (ifb.Timeout_Out !== 1'b1) begin n_bad++; $display("FAIL to_hold_after_arm: got %b, want 1", ifb.Timeout_Out); end
    wave_b(5, 45, t); exp_b.push_back('{p: 32'd50, h: 32'd0});
    n_cmp++; if (ifb.Timeout_Out !== 1'b0) begin n_bad++; $display("FAIL to_cleared: got %b, want 0", ifb.Timeout_Out); end
    n_cmp++; if (obs_b.size() != exp_b.size()) begin n_bad++; $display("FAIL to_count: got %0d, want %0d", obs_b.size(), exp_b.size()); end
    while (exp_b.size() != 0) begin
      e = exp_b.pop_front(); n_cmp++;
      if (obs_b.size() == 0) begin n_bad++; $display("FAIL to_period: got none, want %0d", e.p); end
      else begin o = obs_b.pop_front(); if (o.p !== e.p) begin n_bad++; $display("FAIL to_period: got %0d, want %0d", o.p, e.p); end end
    end
  endtask

  task automatic test_edge_on_timeout();
    int t;
    obs_t o; exp_t e;
    do_reset();
    wave_b(5, 95, t);
    wave_b(5, 20, t); exp_b.push_back('{p: 32'd100, h: 32'd0});
    n_cmp++; if (ifb.Timeout_Out !== 1'b0) begin n_bad++; $display("FAIL eot_timeout: got %b, want 0", ifb.Timeout_Out); end
    n_cmp++; if (vcnt_b != 1) begin n_bad++; $display("FAIL eot_valid_cycles: got %0d, want 1", vcnt_b); end
    n_cmp++; if (obs_b.size() != exp_b.size()) begin n_bad++; $display("FAIL eot_count: got %0d, want %0d", obs_b.size(), exp_b.size()); end
    while (exp_b.size() != 0) begin
      e = exp_b.pop_front(); n_cmp++;
      if (obs_b.size() == 0) begin n_bad++; $display("FAIL eot_period: got none, want %0d", e.p); end
      else begin o = obs_b.pop_front(); if (o.p !== e.p) begin n_bad++; $display("FAIL eot_period: got %0d, want %0d", o.p, e.p); end end
    end
  endtask

`ifdef CLK_METER_DUTY_EN
  task automatic test_duty();
    int t;
    obs_t o; exp_t e;
    do_reset();
    wave_a(300, 700, t);
    for (int i = 0; i < 3; i++) begin
      wave_a(300, 700, t); exp_a.push_back('{p: 32'd1000, h: 32'd300});
    end
    n_cmp++; if (obs_a.size() != exp_a.size()) begin n_bad++; $display("FAIL duty_count: got %0d, want %0d", obs_a.size(), exp_a.size()); end
    while (exp_a.size() != 0) begin
      e = exp_a.pop_front(); n_cmp++;
      if (obs_a.size() == 0) begin n_bad++; $display("FAIL duty_result: got none, want %0d/%0d", e.p, e.h); end
      else begin
        o = obs_a.pop_front();
        if (o.p !== e.p || o.h !== e.h) begin n_bad++; $display("FAIL duty_result: got period %0d high %0d, want period %0d high %0d", o.p, o.h, e.p, e.h); end
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_square_wave();
    test_period_change();
    test_reset_mid();
    test_timeout();
    test_edge_on_timeout();
`ifdef CLK_METER_DUTY_EN
    test_duty();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got no end of test, want end before 5 ms");
    $fatal(1, "watchdog expired");
  end
endmodule
`default_nettype wire
